// File: rtl/uart_cmd_responder.sv
// Command endpoint behind uart_packet_handler: runs PING/ECHO/REG_WRITE/REG_READ and emits one response per request.
// Optional feature macro: UART_RESP_STATS_EN enables err/ok counters and the STATS (0x05) command.
module uart_cmd_responder #(
  parameter int MAX_PAYLOAD_BYTES = 64,
  parameter int REG_COUNT         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pkt_meta_valid,
  output logic                   pkt_meta_ready,
  input  logic [7:0]             pkt_cmd,
  input  logic [15:0]            pkt_length,
  input  logic [1:0]             pkt_error,
  input  logic [7:0]             pkt_payload_data,
  input  logic                   pkt_payload_valid,
  input  logic                   pkt_payload_last,
  output logic                   pkt_payload_ready,
  output logic                   tx_meta_valid,
  input  logic                   tx_meta_ready,
  output logic [7:0]             tx_cmd,
  output logic [15:0]            tx_length,
  output logic [7:0]             tx_payload_data,
  output logic                   tx_payload_valid,
  output logic                   tx_payload_last,
  input  logic                   tx_payload_ready,
  output logic [REG_COUNT*8-1:0] regs_flat,
  output logic                   busy,
  output logic [7:0]             err_count
);

  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int BW = (MAX_PAYLOAD_BYTES > 1) ? $clog2(MAX_PAYLOAD_BYTES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RECV      = 3'd1;
  localparam logic [2:0] S_EXEC      = 3'd2;
  localparam logic [2:0] S_SEND_META = 3'd3;
  localparam logic [2:0] S_SEND_PAY  = 3'd4;

  logic [2:0]  state;
  logic [7:0]  cmd_q;
  logic [15:0] len_q;
  logic [1:0]  perr_q;
  logic        bad_len_q;
  logic [15:0] count;
  logic [15:0] tx_idx;
  logic        echo_mode;
  logic [7:0]  pay_buf [MAX_PAYLOAD_BYTES];
  logic [7:0]  resp [4];
  logic [7:0]  regs [REG_COUNT];

  logic        meta_hs, pay_hs, tx_meta_hs, tx_pay_hs;
  logic [15:0] count_next;
  logic        hit_len, recv_done;

  // Readies are forced low while reset is held so the block never accepts during reset.
  assign pkt_meta_ready    = !rst && (state == S_IDLE);
  assign pkt_payload_ready = !rst && (state == S_RECV);
  assign tx_meta_valid     = (state == S_SEND_META);
  assign tx_payload_valid  = (state == S_SEND_PAY);
  assign tx_payload_last   = (state == S_SEND_PAY) && (tx_idx == tx_length - 16'd1);
  assign busy              = (state != S_IDLE);

  assign meta_hs    = pkt_meta_valid && pkt_meta_ready;
  assign pay_hs     = pkt_payload_valid && pkt_payload_ready;
  assign tx_meta_hs = tx_meta_valid && tx_meta_ready;
  assign tx_pay_hs  = tx_payload_valid && tx_payload_ready;

  assign count_next = count + 16'd1;
  assign hit_len    = (count_next == len_q);
  assign recv_done  = pay_hs && (pkt_payload_last || hit_len);

  always_comb begin
    tx_payload_data = 8'h00;
    if (state == S_SEND_PAY)
      tx_payload_data = echo_mode ? pay_buf[tx_idx[BW-1:0]] : resp[tx_idx[1:0]];
  end

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs[i];
  end

`ifdef UART_RESP_STATS_EN
  logic [15:0] ok_cnt;
  logic [7:0]  err_cnt;
`endif

  logic [7:0]  addr, wdata, err_code;
  logic        known, len_ok, uses_addr, addr_ok, is_err;
  logic [15:0] resp_len;
  logic        resp_echo;
  logic [7:0]  resp_b0, resp_b1, resp_b2;

  assign addr    = pay_buf[0];
  assign wdata   = pay_buf[1];
  assign addr_ok = int'(addr) < REG_COUNT;
  assign is_err  = (err_code != 8'h00);

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    known     = 1'b0;
    len_ok    = 1'b0;
    uses_addr = 1'b0;
    err_code  = 8'h00;
    resp_len  = 16'd0;
    resp_echo = 1'b0;
    resp_b0   = 8'h00;
    resp_b1   = 8'h00;
    resp_b2   = 8'h00;
    case (cmd_q)
      8'h01: begin known = 1'b1; len_ok = (len_q == 16'd0); end
      8'h02: begin known = 1'b1; len_ok = (len_q != 16'd0) && (int'(len_q) <= MAX_PAYLOAD_BYTES); end
      8'h03: begin known = 1'b1; len_ok = (len_q == 16'd2); uses_addr = 1'b1; end
      8'h04: begin known = 1'b1; len_ok = (len_q == 16'd1); uses_addr = 1'b1; end
`ifdef UART_RESP_STATS_EN
      8'h05: begin known = 1'b1; len_ok = (len_q == 16'd0); end
`endif
      default: ;
    endcase
    if (perr_q != 2'b00)             err_code = 8'h04;
    else if (!known)                 err_code = 8'h01;
    else if (!len_ok || bad_len_q)   err_code = 8'h02;
    else if (uses_addr && !addr_ok)  err_code = 8'h03;

    if (err_code != 8'h00) begin
      resp_len = 16'd2;
      resp_b0  = cmd_q;
      resp_b1  = err_code;
    end else begin
      case (cmd_q)
        8'h02: begin resp_len = len_q; resp_echo = 1'b1; end
        8'h03: resp_len = 16'd1;
        8'h04: begin resp_len = 16'd1; resp_b0 = regs[addr[AW-1:0]]; end
`ifdef UART_RESP_STATS_EN
        8'h05: begin resp_len = 16'd3; resp_b0 = ok_cnt[7:0]; resp_b1 = ok_cnt[15:8]; resp_b2 = err_cnt; end
`endif
        default: ;
      endcase
    end
  end

`ifdef UART_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_cnt  <= 16'd0;
      err_cnt <= 8'd0;
    end else if (state == S_EXEC) begin
      if (is_err && err_cnt != 8'hFF)     err_cnt <= err_cnt + 8'd1;
      if (!is_err && ok_cnt != 16'hFFFF)  ok_cnt  <= ok_cnt + 16'd1;
    end
  end
  assign err_count = err_cnt;
`else
  assign err_count = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_q     <= 8'h00;
      len_q     <= 16'd0;
      perr_q    <= 2'b00;
      bad_len_q <= 1'b0;
      count     <= 16'd0;
      tx_idx    <= 16'd0;
      tx_cmd    <= 8'h00;
      tx_length <= 16'd0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
    end else begin
      case (state)
        S_IDLE: if (meta_hs) begin
          cmd_q     <= pkt_cmd;
          len_q     <= pkt_length;
          perr_q    <= pkt_error;
          bad_len_q <= 1'b0;
          count     <= 16'd0;
          state     <= (pkt_length != 16'd0) ? S_RECV : S_EXEC;
        end
        S_RECV: if (pay_hs) begin
          count <= count_next;
          if (recv_done) begin
            bad_len_q <= (pkt_payload_last != hit_len);
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          tx_cmd    <= is_err ? 8'hFF : (cmd_q | 8'h80);
          tx_length <= resp_len;
          if (!is_err && cmd_q == 8'h03) regs[addr[AW-1:0]] <= wdata;
          state     <= S_SEND_META;
        end
        S_SEND_META: if (tx_meta_hs) begin
          tx_idx <= 16'd0;
          state  <= (tx_length != 16'd0) ? S_SEND_PAY : S_IDLE;
        end
        S_SEND_PAY: if (tx_pay_hs) begin
          if (tx_payload_last) state  <= S_IDLE;
          else                 tx_idx <= tx_idx + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: buffer contents are always rewritten before they are read, so this storage carries no reset.
  always_ff @(posedge clk) begin
    if (pay_hs && int'(count) < MAX_PAYLOAD_BYTES)
      pay_buf[count[BW-1:0]] <= pkt_payload_data;
    if (state == S_EXEC) begin
      echo_mode <= resp_echo;
      resp[0]   <= resp_b0;
      resp[1]   <= resp_b1;
      resp[2]   <= resp_b2;
      resp[3]   <= 8'h00;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: a request-level model predicts each response; a monitor checks what the DUT emits.
module tb_uart_cmd_responder;
  localparam int MAXP = 64;
  localparam int NREG = 16;
`ifdef UART_RESP_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pkt_meta_valid = 1'b0, pkt_meta_ready;
  logic [7:0] pkt_cmd = 8'h00;
  logic [15:0] pkt_length = 16'd0;
  logic [1:0] pkt_error = 2'b00;
  logic [7:0] pkt_payload_data = 8'h00;
  logic pkt_payload_valid = 1'b0, pkt_payload_last = 1'b0, pkt_payload_ready;
  logic tx_meta_valid, tx_meta_ready = 1'b0;
  logic [7:0] tx_cmd;
  logic [15:0] tx_length;
  logic [7:0] tx_payload_data;
  logic tx_payload_valid, tx_payload_last, tx_payload_ready = 1'b0;
  logic [NREG*8-1:0] regs_flat;
  logic busy;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_cmd_responder #(.MAX_PAYLOAD_BYTES(MAXP), .REG_COUNT(NREG)) dut (
    .clk(clk), .rst(rst),
    .pkt_meta_valid(pkt_meta_valid), .pkt_meta_ready(pkt_meta_ready),
    .pkt_cmd(pkt_cmd), .pkt_length(pkt_length), .pkt_error(pkt_error),
    .pkt_payload_data(pkt_payload_data), .pkt_payload_valid(pkt_payload_valid),
    .pkt_payload_last(pkt_payload_last), .pkt_payload_ready(pkt_payload_ready),
    .tx_meta_valid(tx_meta_valid), .tx_meta_ready(tx_meta_ready),
    .tx_cmd(tx_cmd), .tx_length(tx_length),
    .tx_payload_data(tx_payload_data), .tx_payload_valid(tx_payload_valid),
    .tx_payload_last(tx_payload_last), .tx_payload_ready(tx_payload_ready),
    .regs_flat(regs_flat), .busy(busy), .err_count(err_count)
  );

  typedef struct packed { logic [7:0] cmd; logic [15:0] len; } hdr_t;
  hdr_t       exp_hdr[$];
  logic [7:0] exp_bytes[$];
  int         lat_q[$];
  logic [7:0] stim_bytes[$];
  logic [7:0] m_regs [NREG];
  int m_ok, m_err;
  int checks = 0, errors = 0;
  int cyc = 0, rem = 0, rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_ok = 0;
    m_err = 0;
  endtask

  // Request-level reference: classify the request, then queue the response it must produce.
  task automatic model_req(input logic [7:0] cmd, input int len, input logic [1:0] perr, input bit bad);
    logic [7:0] code;
    bit known, len_ok;
    code = 8'h00;
    known = (cmd >= 8'h01 && cmd <= 8'h04) || (STATS_EN && cmd == 8'h05);
    case (cmd)
      8'h01: len_ok = (len == 0);
      8'h02: len_ok = (len >= 1 && len <= MAXP);
      8'h03: len_ok = (len == 2);
      8'h04: len_ok = (len == 1);
      8'h05: len_ok = (len == 0);
      default: len_ok = 1'b0;
    endcase
    if (perr != 2'b00) code = 8'h04;
    else if (!known) code = 8'h01;
    else if (!len_ok || bad) code = 8'h02;
    else if ((cmd == 8'h03 || cmd == 8'h04) && int'(stim_bytes[0]) >= NREG) code = 8'h03;
    if (code != 8'h00) begin
      exp_hdr.push_back('{8'hFF, 16'd2});
      exp_bytes.push_back(cmd);
      exp_bytes.push_back(code);
      if (m_err < 255) m_err++;
    end else begin
      case (cmd)
        8'h01: exp_hdr.push_back('{8'h81, 16'd0});
        8'h02: begin
          exp_hdr.push_back('{8'h82, 16'(len)});
          for (int i = 0; i < len; i++) exp_bytes.push_back(stim_bytes[i]);
        end
        8'h03: begin
          m_regs[stim_bytes[0]] = stim_bytes[1];
          exp_hdr.push_back('{8'h83, 16'd1});
          exp_bytes.push_back(8'h00);
        end
        8'h04: begin
          exp_hdr.push_back('{8'h84, 16'd1});
          exp_bytes.push_back(m_regs[stim_bytes[0]]);
        end
        default: begin
          exp_hdr.push_back('{8'h85, 16'd3});
          exp_bytes.push_back(8'(m_ok));
          exp_bytes.push_back(8'(m_ok >> 8));
          exp_bytes.push_back(8'(m_err));
        end
      endcase
      if (m_ok < 65535) m_ok++;
    end
  endtask

  // Drives one request; last_pos marks which byte carries pkt_payload_last (out of range = none).
  task automatic send_req(input logic [7:0] cmd, input int len, input logic [1:0] perr, input int last_pos);
    int nbytes, budget, hs;
    bit bad;
    nbytes = (last_pos >= 0 && last_pos < len) ? last_pos + 1 : len;
    bad = (len > 0) && (last_pos != len - 1);
    model_req(cmd, len, perr, bad);
    @(posedge clk); #1;
    pkt_meta_valid = 1'b1;
    pkt_cmd = cmd;
    pkt_length = 16'(len);
    pkt_error = perr;
    budget = 0;
    forever begin
      pkt_payload_valid = 1'($urandom_range(0, 1));
      pkt_payload_last = 1'($urandom_range(0, 1));
      pkt_payload_data = 8'($urandom);
      @(negedge clk);
      if (pkt_meta_ready) break;
      if (++budget > 4000) begin
        fail("meta_accept_timeout");
        pkt_meta_valid = 1'b0;
        pkt_payload_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    hs = cyc;
    @(posedge clk); #1;
    pkt_meta_valid = 1'b0;
    pkt_payload_valid = 1'b0;
    pkt_payload_last = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        pkt_meta_valid = 1'($urandom_range(0, 1));
        pkt_cmd = 8'($urandom);
        pkt_length = 16'($urandom);
        @(posedge clk); #1;
      end
      pkt_meta_valid = 1'b0;
      pkt_payload_data = stim_bytes[i];
      pkt_payload_valid = 1'b1;
      pkt_payload_last = (i == last_pos);
      budget = 0;
      forever begin
        @(negedge clk);
        if (pkt_payload_ready) break;
        if (++budget > 4000) begin
          fail("payload_accept_timeout");
          pkt_payload_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      hs = cyc;
      @(posedge clk); #1;
      pkt_payload_valid = 1'b0;
      pkt_payload_last = 1'b0;
    end
    lat_q.push_back(hs);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      if (++budget > 6000) begin
        fail("response_drain_timeout");
        return;
      end
    end while (exp_hdr.size() != 0 || rem != 0 || lat_q.size() != 0 || busy);
  endtask

  task automatic rand_bytes(input int n);
    stim_bytes.delete();
    for (int i = 0; i < n; i++) stim_bytes.push_back(8'($urandom));
  endtask

  // Downstream ready patterns: 0 always ready, 1 payload ready toggling, 2 random.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: begin tx_meta_ready = 1'b1; tx_payload_ready = 1'b1; end
      1: begin tx_meta_ready = 1'b1; tx_payload_ready = ~tx_payload_ready; end
      default: begin
        tx_meta_ready = 1'($urandom_range(0, 1));
        tx_payload_ready = 1'($urandom_range(0, 1));
      end
    endcase
  end

  logic prev_mv = 1'b0, prev_mr = 1'b0, prev_pv = 1'b0, prev_pr = 1'b0, prev_plast = 1'b0;
  logic [7:0] prev_cmd = 8'h00, prev_pdata = 8'h00;
  logic [15:0] prev_len = 16'd0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_mv = 1'b0;
      prev_pv = 1'b0;
    end else begin
      if (tx_meta_valid && !prev_mv) begin
        if (lat_q.size() == 0) fail("meta_without_request");
        else check("latency", cyc, lat_q.pop_front() + 2);
      end
      if (prev_mv && !prev_mr)
        check("meta_hold", {tx_meta_valid, tx_cmd, tx_length}, {1'b1, prev_cmd, prev_len});
      if (prev_pv && !prev_pr)
        check("pay_hold", {tx_payload_valid, tx_payload_last, tx_payload_data}, {1'b1, prev_plast, prev_pdata});
      if (tx_meta_valid && tx_meta_ready) begin
        if (exp_hdr.size() == 0) fail("unexpected_meta");
        else begin
          hdr_t h;
          h = exp_hdr.pop_front();
          check("tx_cmd", tx_cmd, h.cmd);
          check("tx_length", tx_length, h.len);
          rem = int'(h.len);
        end
      end else if (tx_payload_valid && tx_payload_ready) begin
        if (rem == 0 || exp_bytes.size() == 0) fail("unexpected_payload");
        else begin
          check("tx_data", tx_payload_data, exp_bytes.pop_front());
          check("tx_last", tx_payload_last, rem == 1);
          rem--;
        end
      end
      prev_mv = tx_meta_valid;
      prev_mr = tx_meta_ready;
      prev_cmd = tx_cmd;
      prev_len = tx_length;
      prev_pv = tx_payload_valid;
      prev_pr = tx_payload_ready;
      prev_plast = tx_payload_last;
      prev_pdata = tx_payload_data;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] r_cmd;
  int r_len, r_lp, r_k, budget;
  logic [1:0] r_pe;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_meta_ready", pkt_meta_ready, 1'b0);
    check("rst_pay_ready", pkt_payload_ready, 1'b0);
    check("rst_tx_valids", {tx_meta_valid, tx_payload_valid, tx_payload_last}, 3'b000);
    check("rst_tx_fields", {tx_cmd, tx_length, tx_payload_data}, 32'h0);
    check("rst_regs", regs_flat, '0);
    check("rst_busy_err", {busy, err_count}, 9'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    rdy_mode = 0;
    send_req(8'h01, 0, 2'b00, -1);
    wait_idle();

    rdy_mode = 1;
    stim_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_req(8'h02, 4, 2'b00, 3);
    wait_idle();

    rdy_mode = 0;
    stim_bytes = '{8'h05, 8'hC3};
    send_req(8'h03, 2, 2'b00, 1);
    stim_bytes = '{8'h05};
    send_req(8'h04, 1, 2'b00, 0);
    wait_idle();
    check("reg5_value", regs_flat[47:40], 8'hC3);

    stim_bytes = '{8'h10};
    send_req(8'h04, 1, 2'b00, 0);
    rand_bytes(3);
    send_req(8'h7E, 3, 2'b00, 2);
    rand_bytes(65);
    send_req(8'h02, 65, 2'b00, 64);
    wait_idle();
    check("err_count_three", err_count, STATS_EN ? 8'd3 : 8'd0);

    send_req(8'h01, 0, 2'b10, -1);
    rand_bytes(5);
    send_req(8'h02, 5, 2'b00, 1);
    rand_bytes(3);
    send_req(8'h02, 3, 2'b00, -1);
    rand_bytes(2);
    send_req(8'h01, 2, 2'b00, 1);
    wait_idle();

    rdy_mode = 1;
    rand_bytes(8);
    send_req(8'h02, 8, 2'b00, 7);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(tx_payload_valid && tx_payload_ready) && budget < 2000);
    if (budget >= 2000) fail("send_pay_not_reached");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_hdr.delete();
    exp_bytes.delete();
    lat_q.delete();
    rem = 0;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valids", {tx_meta_valid, tx_payload_valid}, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_regs", regs_flat, '0);
    check("midrst_fields", {tx_cmd, tx_length, err_count}, 32'h0);

    rdy_mode = 0;
    send_req(8'h01, 0, 2'b00, -1);
    rand_bytes(2);
    send_req(8'h02, 2, 2'b00, 1);
    send_req(8'h7E, 0, 2'b00, -1);
    send_req(8'h05, 0, 2'b00, -1);
    wait_idle();

    for (int n = 0; n < 150; n++) begin
      r_k = int'($urandom_range(0, 9));
      case (r_k)
        0, 1: begin r_cmd = 8'h01; r_len = 0; end
        2, 3: begin r_cmd = 8'h02; r_len = int'($urandom_range(1, 12)); end
        4, 5: begin r_cmd = 8'h03; r_len = 2; end
        6, 7: begin r_cmd = 8'h04; r_len = 1; end
        8:    begin r_cmd = 8'h05; r_len = 0; end
        default: begin r_cmd = 8'($urandom); r_len = int'($urandom_range(0, 4)); end
      endcase
      if ($urandom_range(0, 9) == 0) r_len = int'($urandom_range(0, 6));
      if (r_cmd == 8'h02 && $urandom_range(0, 19) == 0) r_len = int'($urandom_range(60, 68));
      rand_bytes(r_len);
      if ((r_cmd == 8'h03 || r_cmd == 8'h04) && r_len > 0) stim_bytes[0] = 8'($urandom_range(0, 19));
      r_pe = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_lp = r_len - 1;
      if ($urandom_range(0, 9) == 0) r_lp = int'($urandom_range(0, r_len + 1)) - 1;
      rdy_mode = int'($urandom_range(0, 2));
      send_req(r_cmd, r_len, r_pe, r_lp);
    end
    wait_idle();

    for (int i = 0; i < NREG; i++)
      check($sformatf("final_reg%0d", i), regs_flat[8*i +: 8], m_regs[i]);
    check("final_err_count", err_count, STATS_EN ? 8'(m_err) : 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
